// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arbiter
// Description : Round-robin burst arbiter sharing one FIFO write port among
//               NUM_REQ valid/ready producers, with full back-pressure.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst_,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_din,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    logic [0:0]            r_state;
    logic [ID_W-1:0]       r_grant_id;
    logic [ID_W-1:0]       r_last_grant;
    logic [CNT_W-1:0]      r_beat_cnt;

    logic [ID_W-1:0]       w_idx;
    logic [ID_W-1:0]       w_winner;
    logic                  w_found;
    logic                  w_xfer;
    logic                  w_burst_end;
    logic [CNT_W-1:0]      w_cnt_inc;
    logic [NUM_REQ-1:0]    w_ready;
    logic [DATA_WIDTH-1:0] w_din;

    // Search starts one past the previous winner so every producer gets a turn.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = ID_W'((int'(r_last_grant) + k) % NUM_REQ);
            if (!w_found && req_valid[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    assign w_xfer      = (r_state == S_BURST) && req_valid[r_grant_id] && !fifo_full;
    assign w_cnt_inc   = r_beat_cnt + CNT_W'(1);
    assign w_burst_end = req_last[r_grant_id] || (w_cnt_inc == CNT_W'(MAX_BURST));

    // Ready depends only on the lock and full, never on the grantee's valid.
    always_comb begin
        w_ready = '0;
        if ((r_state == S_BURST) && !fifo_full) begin
            w_ready[r_grant_id] = 1'b1;
        end
    end

    assign w_din = w_xfer ? req_data[int'(r_grant_id)*DATA_WIDTH +: DATA_WIDTH] : '0;

    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            r_state      <= S_IDLE;
            r_grant_id   <= '0;
            r_last_grant <= ID_W'(NUM_REQ - 1);
            r_beat_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant_id   <= w_winner;
                        r_last_grant <= w_winner;
                        r_beat_cnt   <= '0;
                        r_state      <= S_BURST;
                    end
                end
                S_BURST: begin
                    if (w_xfer) begin
                        r_beat_cnt <= w_cnt_inc;
                        if (w_burst_end) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = w_ready;
    assign fifo_wr_en = w_xfer;
    assign fifo_din   = w_din;
    assign grant_id   = r_grant_id;
    assign busy       = (r_state == S_BURST);

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_wr_arbiter
// Description : Directed self-checking bench for fifo_wr_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 8;
    localparam int MAX_BURST  = 4;

    logic                          clk;
    logic                          rst_;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_full;
    logic                          fifo_wr_en;
    logic [DATA_WIDTH-1:0]         fifo_din;
    logic [1:0]                    grant_id;
    logic                          busy;

    int n_vec;
    int n_err;

    fifo_wr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DATA_WIDTH(DATA_WIDTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk       (clk),
        .rst_      (rst_),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_data  (req_data),
        .req_ready (req_ready),
        .fifo_full (fifo_full),
        .fifo_wr_en(fifo_wr_en),
        .fifo_din  (fifo_din),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected summary before 200000");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int i, input logic [7:0] v);
        req_data[i*DATA_WIDTH +: DATA_WIDTH] = v;
    endtask

    // Checks the combinational write-side outputs after inputs settle.
    task automatic chk_wr(input string tag, input logic en, input logic [7:0] din,
                          input logic [3:0] rdy);
        #1;
        chk({tag, "_wr_en"}, 32'(fifo_wr_en), 32'(en));
        chk({tag, "_din"},   32'(fifo_din),   32'(din));
        chk({tag, "_ready"}, 32'(req_ready),  32'(rdy));
    endtask

    task automatic do_reset();
        rst_ = 1'b1;
        step();
        rst_ = 1'b0;
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst_      = 1'b1;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        fifo_full = 1'b0;

        // Reset state
        #1;
        chk("rst_busy",  32'(busy),     32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        chk_wr("rst", 1'b0, 8'h00, 4'h0);
        step();
        rst_ = 1'b0;

        // Round-robin with single-beat bursts
        req_valid = 4'hF;
        req_last  = 4'hF;
        for (int i = 0; i < NUM_REQ; i++) set_data(i, 8'(8'h10 + i));
        for (int n = 0; n < 6; n++) begin
            step();
            chk("rr_busy",  32'(busy),     32'd1);
            chk("rr_grant", 32'(grant_id), 32'(n % 4));
            chk_wr("rr", 1'b1, 8'(8'h10 + (n % 4)), 4'(1 << (n % 4)));
            step();
            chk("rr_bubble_busy", 32'(busy), 32'd0);
            chk_wr("rr_bubble", 1'b0, 8'h00, 4'h0);
        end
        req_valid = '0;
        req_last  = '0;

        // Burst cap: requester 2 never marks last
        do_reset();
        req_valid = 4'b0100;
        set_data(2, 8'h20);
        for (int b = 0; b < 8; b++) begin
            if (b % 4 == 0) begin
                step();
                chk("cap_grant", 32'(grant_id), 32'd2);
                chk("cap_busy",  32'(busy),     32'd1);
            end
            chk_wr("cap", 1'b1, 8'(8'h20 + b), 4'b0100);
            step();
            set_data(2, 8'(8'h21 + b));
            if (b % 4 == 3) begin
                chk("cap_end_busy", 32'(busy), 32'd0);
                chk_wr("cap_end", 1'b0, 8'h00, 4'h0);
            end
        end
        req_valid = '0;

        // Full back-pressure on requester 1
        do_reset();
        req_valid = 4'b0010;
        set_data(1, 8'hA0);
        step();
        chk("bp_grant", 32'(grant_id), 32'd1);
        chk_wr("bp_b0", 1'b1, 8'hA0, 4'b0010);
        step();
        set_data(1, 8'hA1);
        fifo_full = 1'b1;
        for (int c = 0; c < 3; c++) begin
            chk_wr("bp_full", 1'b0, 8'h00, 4'h0);
            chk("bp_full_busy", 32'(busy), 32'd1);
            step();
        end
        fifo_full = 1'b0;
        chk_wr("bp_b1", 1'b1, 8'hA1, 4'b0010);
        step();
        set_data(1, 8'hA2);
        req_last = 4'b0010;
        chk_wr("bp_b2", 1'b1, 8'hA2, 4'b0010);
        step();
        chk("bp_done_busy", 32'(busy), 32'd0);
        req_valid = '0;
        req_last  = '0;

        // Mid-burst valid gap on requester 3 while requester 0 waits
        do_reset();
        req_valid = 4'b1000;
        set_data(3, 8'h30);
        set_data(0, 8'h55);
        step();
        req_valid = 4'b1001;
        chk("gap_grant", 32'(grant_id), 32'd3);
        chk_wr("gap_b0", 1'b1, 8'h30, 4'b1000);
        step();
        set_data(3, 8'h31);
        req_valid = 4'b0001;
        for (int c = 0; c < 2; c++) begin
            chk_wr("gap_hold", 1'b0, 8'h00, 4'b1000);
            chk("gap_hold_grant", 32'(grant_id), 32'd3);
            step();
        end
        req_valid = 4'b1001;
        req_last  = 4'b1000;
        chk_wr("gap_last", 1'b1, 8'h31, 4'b1000);
        step();
        req_last = 4'b0000;
        chk("gap_idle_busy", 32'(busy), 32'd0);
        chk_wr("gap_idle", 1'b0, 8'h00, 4'h0);
        step();
        chk("gap_next_grant", 32'(grant_id), 32'd0);
        chk_wr("gap_next", 1'b1, 8'h55, 4'b0001);
        req_valid = '0;

        // Asynchronous reset in the middle of a burst
        do_reset();
        req_valid = 4'b0010;
        set_data(1, 8'h40);
        step();
        chk_wr("ar_b0", 1'b1, 8'h40, 4'b0010);
        step();
        set_data(1, 8'h41);
        chk_wr("ar_b1", 1'b1, 8'h41, 4'b0010);
        #2;
        rst_ = 1'b1;
        chk_wr("ar_async", 1'b0, 8'h00, 4'h0);
        chk("ar_busy",  32'(busy),     32'd0);
        chk("ar_grant", 32'(grant_id), 32'd0);
        step();
        rst_      = 1'b0;
        req_valid = 4'b0011;
        set_data(0, 8'h01);
        step();
        chk("ar_first_grant", 32'(grant_id), 32'd0);
        chk_wr("ar_first", 1'b1, 8'h01, 4'b0001);
        req_valid = '0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
